data_mem_arbiter: RTL and testbench

Sequences and shares the single-port data memory between the processor core (load/store commands from the control decode) and the program/data loader used during init. The memory has one-cycle read latency, so the block issues the access, stalls the core for the wait state, returns read data, and gives the loader idle cycles or a starvation-bounded forced slot. It sits between the core's memRead/memWrite path and the data memory macro.

---
 rtl/data_mem_arbiter_pkg.sv | 16 +
 rtl/arb_wait_counter.sv | 29 ++
 rtl/data_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int unsigned ARB_AW       = 8;
    localparam int unsigned ARB_DW       = 8;
    localparam int unsigned ARB_MAX_WAIT = 4;
    // Wide enough for any MAX_WAIT in 1..15.
    localparam int unsigned ARB_WCW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        CORE_RD,
        LD_RD
    } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Loader starvation counter: counts cycles a loader request waits, saturating at MAX_WAIT,
// and raises force_grant once the limit is reached.
module arb_wait_counter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic ld_valid,
    input  logic ld_ready,
    output logic force_grant
);

    logic [ARB_WCW-1:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (!ld_valid || ld_ready) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != ARB_WCW'(MAX_WAIT)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign force_grant = (wait_cnt_q == ARB_WCW'(MAX_WAIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between core load/store and the init loader.
// Optional DATA_MEM_ARB_STATS_EN adds saturating stall_count / forced_count outputs.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = ARB_AW,
    parameter int unsigned DW       = ARB_DW,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          memRead,
    input  logic          memWrite,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          ld_valid,
    input  logic          ld_write,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ready,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_count,
    output logic [7:0]    forced_count
`endif
);

    arb_state_t state_q, state_d;
    logic       force_grant;
    logic       core_pend, core_req, ld_req;
    logic       core_gnt, ld_gnt;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .force_grant (force_grant)
    );

    // Grant decision; requests are masked during reset so outputs sit at reset values.
    always_comb begin
        core_pend = (memRead || memWrite) && !reset;
        core_req  = core_pend && !init;
        ld_req    = ld_valid && !reset;
        core_gnt  = 1'b0;
        ld_gnt    = 1'b0;
        if (init) begin
            ld_gnt = ld_req;
        end else if (force_grant && ld_req) begin
            ld_gnt = 1'b1;
        end else if (core_req) begin
            core_gnt = 1'b1;
        end else begin
            ld_gnt = ld_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (core_gnt && !memWrite) begin
            state_d = CORE_RD;
        end else if (ld_gnt && !ld_write) begin
            state_d = LD_RD;
        end
    end

    // A back-to-back read issued in CORE_RD overlaps the previous load's data cycle,
    // so it does not stall; a fresh read from any other state does.
    always_comb begin
        mem_en     = core_gnt || ld_gnt;
        mem_we     = core_gnt ? memWrite : (ld_gnt && ld_write);
        mem_addr   = core_gnt ? core_addr : (ld_gnt ? ld_addr : '0);
        mem_wdata  = core_gnt ? core_wdata : (ld_gnt ? ld_wdata : '0);
        ld_ready   = ld_gnt;
        core_stall = core_pend && (!core_gnt || (!memWrite && state_q != CORE_RD));
        core_rdata = (state_q == CORE_RD && !reset) ? mem_rdata : '0;
        ld_rvalid  = (state_q == LD_RD) && !reset;
        ld_rdata   = (state_q == LD_RD && !reset) ? mem_rdata : '0;
    end

`ifdef DATA_MEM_ARB_STATS_EN
    logic [15:0] stall_count_q;
    logic [7:0]  forced_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q  <= '0;
            forced_count_q <= '0;
        end else begin
            if (core_stall && stall_count_q != 16'hffff) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
            if (ld_gnt && force_grant && !init && forced_count_q != 8'hff) begin
                forced_count_q <= forced_count_q + 8'd1;
            end
        end
    end

    assign stall_count  = stall_count_q;
    assign forced_count = forced_count_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter against a cycle-level reference model.
module tb_data_mem_arbiter;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk;
    logic          reset;
    logic          init;
    logic          memRead;
    logic          memWrite;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          ld_valid;
    logic          ld_write;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ready;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DATA_MEM_ARB_STATS_EN
    logic [15:0]   stall_count;
    logic [7:0]    forced_count;
`endif

    data_mem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .core_stall   (core_stall),
        .ld_valid     (ld_valid),
        .ld_write     (ld_write),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_ready     (ld_ready),
        .ld_rvalid    (ld_rvalid),
        .ld_rdata     (ld_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef DATA_MEM_ARB_STATS_EN
        ,
        .stall_count  (stall_count),
        .forced_count (forced_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro: one-cycle read latency.
    logic [DW-1:0] mem [0:255] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    // Reference model state: who owns the returning read, its data, loader wait cycles.
    logic [DW-1:0] ref_mem [0:255] = '{default: '0};
    int            m_out;       // 0 none, 1 core, 2 loader
    logic [DW-1:0] m_rd;
    int            m_wait;
    logic          m_ld_gnt;
    int            m_stalls;
    int            m_forced;
    logic          obs_ready;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already applied; compares, then advances one clock.
    task automatic step();
        int            who;
        logic          cw;
        logic          e_stall;
        logic          e_we;
        logic [DW-1:0] e_crd;
        logic [DW-1:0] e_lrd;
        #2;
        cw  = (memRead || memWrite) && !reset;
        who = 0;
        if (!reset) begin
            if (init) who = ld_valid ? 2 : 0;
            else if (ld_valid && m_wait >= int'(MAX_WAIT)) who = 2;
            else if (cw) who = 1;
            else if (ld_valid) who = 2;
        end
        e_stall = cw && (who != 1 || (!memWrite && m_out != 1));
        e_we    = (who == 1) ? memWrite : ((who == 2) ? ld_write : 1'b0);
        e_crd   = (!reset && m_out == 1) ? m_rd : '0;
        e_lrd   = (!reset && m_out == 2) ? m_rd : '0;
        check("core_stall", 32'(core_stall), 32'(e_stall));
        check("core_rdata", 32'(core_rdata), 32'(e_crd));
        check("ld_ready", 32'(ld_ready), 32'(who == 2));
        check("ld_rvalid", 32'(ld_rvalid), 32'(!reset && m_out == 2));
        check("ld_rdata", 32'(ld_rdata), 32'(e_lrd));
        check("mem_en", 32'(mem_en), 32'(who != 0));
        check("mem_we", 32'(mem_we), 32'(e_we));
        if (who == 1) check("mem_addr", 32'(mem_addr), 32'(core_addr));
        else if (who == 2) check("mem_addr", 32'(mem_addr), 32'(ld_addr));
        else if (reset) check("mem_addr_rst", 32'(mem_addr), 32'd0);
        if (e_we) check("mem_wdata", 32'(mem_wdata), 32'((who == 1) ? core_wdata : ld_wdata));
        else if (reset) check("mem_wdata_rst", 32'(mem_wdata), 32'd0);
        obs_ready = ld_ready;
        @(posedge clk);
        if (reset) begin
            m_out    = 0;
            m_wait   = 0;
            m_stalls = 0;
            m_forced = 0;
        end else begin
            if (e_stall && m_stalls < 65535) m_stalls++;
            if (who == 2 && !init && m_wait >= int'(MAX_WAIT) && m_forced < 255) m_forced++;
            m_out = 0;
            if (who == 1) begin
                if (memWrite) ref_mem[core_addr] = core_wdata;
                else begin
                    m_out = 1;
                    m_rd  = ref_mem[core_addr];
                end
            end else if (who == 2) begin
                if (ld_write) ref_mem[ld_addr] = ld_wdata;
                else begin
                    m_out = 2;
                    m_rd  = ref_mem[ld_addr];
                end
            end
            if (ld_valid && who != 2) m_wait = (m_wait < int'(MAX_WAIT)) ? m_wait + 1 : m_wait;
            else m_wait = 0;
        end
        m_ld_gnt = (who == 2);
        #1;
    endtask

    task automatic quiet();
        reset      = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        ld_valid   = 1'b0;
        ld_write   = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        ld_addr    = '0;
        ld_wdata   = '0;
    endtask

    initial begin
        int gi;
        n_cmp = 0; n_err = 0;
        m_out = 0; m_rd = '0; m_wait = 0; m_ld_gnt = 1'b0;
        m_stalls = 0; m_forced = 0; obs_ready = 1'b0;
        quiet();
        init  = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Core store then load of 0x10.
        memWrite = 1'b1; core_addr = 8'h10; core_wdata = 8'ha5;
        step();
        memWrite = 1'b0; memRead = 1'b1;
        step();
        memRead = 1'b0;
        check("plan_load_data", 32'(core_rdata), 32'h0a5);
        step();

        // init: loader writes 0..7 back-to-back, core read ignored.
        init = 1'b1; memRead = 1'b1; core_addr = 8'h10;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1; ld_write = 1'b1; ld_addr = 8'(i); ld_wdata = 8'(8'h40 + i);
            step();
            check("plan_init_ready", 32'(obs_ready), 32'd1);
        end
        quiet(); init = 1'b0;
        step();
        for (int i = 0; i < 8; i++) check("plan_init_mem", 32'(mem[i]), 32'(8'h40 + i));

        // Core loads every cycle; loader forced in after MAX_WAIT waits.
        memRead = 1'b1; core_addr = 8'h30;
        ld_valid = 1'b1; ld_write = 1'b1; ld_addr = 8'h50; ld_wdata = 8'h77;
        gi = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_ready && gi < 0) begin
                gi = i;
                ld_valid = 1'b0;
            end
        end
        check("plan_forced_slot", 32'(gi), 32'd4);
        quiet();
        step();

        // Loader read of 0x10 returns core-stored data.
        ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 8'h10;
        step();
        ld_valid = 1'b0;
        check("plan_ld_rvalid", 32'(ld_rvalid), 32'd1);
        check("plan_ld_rdata", 32'(ld_rdata), 32'h0a5);
        step();

        // Read+write together: write wins.
        memRead = 1'b1; memWrite = 1'b1; core_addr = 8'h20; core_wdata = 8'h3c;
        step();
        memWrite = 1'b0;
        step();
        memRead = 1'b0;
        check("plan_rw_data", 32'(core_rdata), 32'h03c);
        step();

        // Reset while a core read is outstanding.
        memRead = 1'b1; core_addr = 8'h10;
        step();
        memRead = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("plan_rst_rdata", 32'(core_rdata), 32'd0);
        check("plan_rst_rvalid", 32'(ld_rvalid), 32'd0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 39) == 0) init = ~init;
            memRead    = ($urandom_range(0, 99) < 45);
            memWrite   = ($urandom_range(0, 99) < 25);
            core_addr  = 8'($urandom_range(0, 31));
            core_wdata = 8'($urandom);
            if (!(ld_valid && !m_ld_gnt)) begin
                ld_valid = ($urandom_range(0, 99) < 40);
                ld_write = ($urandom_range(0, 1) == 1);
                ld_addr  = 8'($urandom_range(0, 31));
                ld_wdata = 8'($urandom);
            end
            step();
        end
        quiet();
        step();
`ifdef DATA_MEM_ARB_STATS_EN
        check("stall_count", 32'(stall_count), 32'(m_stalls));
        check("forced_count", 32'(forced_count), 32'(m_forced));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
